idct_block_checker: RTL and testbench

- Sits at the output end of the dct_idct path and checks what comes out against what went in.
- Taps the 8-bit raster pixel stream fed into the DCT (xin) and the reconstructed stream leaving the IDCT (idct_2d).
- Buffers each complete 8x8 input block and compares the next 64 output samples against it, in the same raster order, with a tolerance.
- Reports per-block error statistics and sticky protocol-violation flags.

---
 rtl/idct_chk_pkg.sv | 23 ++
 rtl/idct_ref_ram.sv | 22 ++
 rtl/idct_block_checker.sv | 127 ++++++++++++
 tb/tb_idct_block_checker.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_chk_pkg.sv
// Shared types, sizes and helpers for the IDCT block checker.
package idct_chk_pkg;

    localparam int BLK_N = 64;
    localparam int IDX_W = 6;

    typedef enum logic [1:0] {
        WAIT_REF,
        COMPARE,
        REPORT
    } chk_state_t;

    // Unsigned |a - b| formed at 9 bits, clamped to 8 bits.
    function automatic logic [7:0] abs_diff8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] d;
        if (a >= b)
            d = {1'b0, a} - {1'b0, b};
        else
            d = {1'b0, b} - {1'b0, a};
        return (d > 9'd255) ? 8'hFF : d[7:0];
    endfunction

endpackage

// File: rtl/idct_ref_ram.sv
// Ping-pong reference store: two 64-entry halves, synchronous write, asynchronous read.
module idct_ref_ram
    import idct_chk_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [IDX_W:0]   wr_addr,
    input  logic [7:0]       wr_data,
    input  logic [IDX_W:0]   rd_addr,
    output logic [7:0]       rd_data
);

    logic [7:0] mem [0:2*BLK_N-1];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/idct_block_checker.sv
// Buffers 8x8 input blocks and checks the reconstructed output stream against them
// sample by sample, reporting per-block error statistics and sticky protocol flags.
module idct_block_checker
    import idct_chk_pkg::*;
#(
    parameter int TOL = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        in_valid,
    input  logic [7:0]  xin,
    input  logic        out_valid,
    input  logic [7:0]  idct_2d,
    output logic        blk_done,
    output logic        blk_pass,
    output logic [6:0]  blk_err_cnt,
    output logic [7:0]  blk_max_err,
    output logic [15:0] blk_total,
    output logic        ovf,
    output logic        unf
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLK_N - 1);

    chk_state_t       state_reg, state_next;
    logic [IDX_W-1:0] wr_idx_reg, rd_idx_reg;
    logic             wr_half_reg, rd_half_reg;
    logic [1:0]       pending_reg, pending_next;
    logic [6:0]       err_cnt_reg;
    logic [7:0]       max_err_reg;

    logic             in_drop, wr_en, wr_last;
    logic             cmp_en, cmp_last, report;
    logic [7:0]       ref_pix, diff;

    assign in_drop  = in_valid && (pending_reg == 2'd2);
    assign wr_en    = in_valid && !in_drop;
    assign wr_last  = wr_en && (wr_idx_reg == LAST_IDX);
    assign cmp_en   = (state_reg == COMPARE) && out_valid;
    assign cmp_last = cmp_en && (rd_idx_reg == LAST_IDX);
    assign report   = (state_reg == REPORT);
    assign diff     = abs_diff8(idct_2d, ref_pix);

    idct_ref_ram u_ref_ram (
        .clk     (CLK),
        .wr_en   (wr_en),
        .wr_addr ({wr_half_reg, wr_idx_reg}),
        .wr_data (xin),
        .rd_addr ({rd_half_reg, rd_idx_reg}),
        .rd_data (ref_pix)
    );

    // A block finishing on the write side while another is reported leaves pending unchanged.
    always_comb begin
        pending_next = pending_reg;
        case ({wr_last, report})
            2'b10:   pending_next = pending_reg + 2'd1;
            2'b01:   pending_next = pending_reg - 2'd1;
            default: pending_next = pending_reg;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            WAIT_REF: if (pending_reg != 2'd0) state_next = COMPARE;
            COMPARE:  if (cmp_last) state_next = REPORT;
            REPORT:   state_next = (pending_next != 2'd0) ? COMPARE : WAIT_REF;
            default:  state_next = WAIT_REF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg   <= WAIT_REF;
            wr_idx_reg  <= '0;
            wr_half_reg <= 1'b0;
            rd_idx_reg  <= '0;
            rd_half_reg <= 1'b0;
            pending_reg <= 2'd0;
            err_cnt_reg <= 7'd0;
            max_err_reg <= 8'd0;
            blk_done    <= 1'b0;
            blk_pass    <= 1'b0;
            blk_err_cnt <= 7'd0;
            blk_max_err <= 8'd0;
            blk_total   <= 16'd0;
            ovf         <= 1'b0;
            unf         <= 1'b0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            blk_done    <= report;

            if (wr_en) begin
                wr_idx_reg <= wr_idx_reg + IDX_W'(1);
                if (wr_last)
                    wr_half_reg <= ~wr_half_reg;
            end
            if (in_drop)
                ovf <= 1'b1;

            // Output samples outside COMPARE have no reference to check against.
            if (out_valid && (state_reg != COMPARE))
                unf <= 1'b1;

            if (cmp_en) begin
                rd_idx_reg <= rd_idx_reg + IDX_W'(1);
                if (diff > 8'(TOL))
                    err_cnt_reg <= err_cnt_reg + 7'd1;
                if (diff > max_err_reg)
                    max_err_reg <= diff;
            end

            if (report) begin
                blk_pass    <= (err_cnt_reg == 7'd0);
                blk_err_cnt <= err_cnt_reg;
                blk_max_err <= max_err_reg;
                blk_total   <= blk_total + 16'd1;
                rd_half_reg <= ~rd_half_reg;
                err_cnt_reg <= 7'd0;
                max_err_reg <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_idct_block_checker.sv
// Directed self-checking bench for idct_block_checker.
module tb_idct_block_checker;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, out_valid;
    logic [7:0]  xin, idct_2d;
    logic        blk_done, blk_pass, ovf, unf;
    logic [6:0]  blk_err_cnt;
    logic [7:0]  blk_max_err;
    logic [15:0] blk_total;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int pass_cnt = 0;

    logic [7:0] in_buf  [64];
    logic [7:0] out_buf [64];

    idct_block_checker #(.TOL(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .in_valid    (in_valid),
        .xin         (xin),
        .out_valid   (out_valid),
        .idct_2d     (idct_2d),
        .blk_done    (blk_done),
        .blk_pass    (blk_pass),
        .blk_err_cnt (blk_err_cnt),
        .blk_max_err (blk_max_err),
        .blk_total   (blk_total),
        .ovf         (ovf),
        .unf         (unf)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (blk_done === 1'b1) begin
            done_cnt++;
            if (blk_pass === 1'b1) pass_cnt++;
            $display("block report: total=%0d err_cnt=%0d max_err=%0d pass=%0b",
                     blk_total, blk_err_cnt, blk_max_err, blk_pass);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] pix(input int b, input int i);
        return 8'((b * 37 + i * 3 + 5) & 255);
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; in_valid = 1'b0; out_valid = 1'b0; xin = 8'h00; idct_2d = 8'h00;
        tick();
        RST = 1'b0;
    endtask

    task automatic load_pattern(input int b);
        for (int i = 0; i < 64; i++) begin
            in_buf[i]  = pix(b, i);
            out_buf[i] = pix(b, i);
        end
    endtask

    task automatic send_in(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1; xin = in_buf[i];
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic send_out();
        for (int i = 0; i < 64; i++) begin
            out_valid = 1'b1; idct_2d = out_buf[i];
            tick();
        end
        out_valid = 1'b0;
    endtask

    // Samples blk_done in the REPORT cycle (must be low) and one cycle later (must be high).
    task automatic await_report(output logic early, output logic on_time);
        early = blk_done;
        tick();
        on_time = blk_done;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (blk_done !== 1'b0) begin n_bad++; $display("FAIL reset_blk_done: got %b, want 0", blk_done); end
        n_cmp++; if (blk_pass !== 1'b0) begin n_bad++; $display("FAIL reset_blk_pass: got %b, want 0", blk_pass); end
        n_cmp++; if (blk_err_cnt !== 7'd0) begin n_bad++; $display("FAIL reset_err_cnt: got %0d, want 0", blk_err_cnt); end
        n_cmp++; if (blk_max_err !== 8'd0) begin n_bad++; $display("FAIL reset_max_err: got %0d, want 0", blk_max_err); end
        n_cmp++; if (blk_total !== 16'd0) begin n_bad++; $display("FAIL reset_total: got %0d, want 0", blk_total); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b, want 0", ovf); end
        n_cmp++; if (unf !== 1'b0) begin n_bad++; $display("FAIL reset_unf: got %b, want 0", unf); end
    endtask

    task automatic test_match();
        logic early, on_time;
        int d0;
        do_reset();
        d0 = done_cnt;
        for (int i = 0; i < 64; i++) begin in_buf[i] = 8'h28; out_buf[i] = 8'h28; end
        send_in(64);
        repeat (3) tick();
        send_out();
        await_report(early, on_time);
        n_cmp++; if (early !== 1'b0) begin n_bad++; $display("FAIL match_latency_early: got %b, want 0", early); end
        n_cmp++; if (on_time !== 1'b1) begin n_bad++; $display("FAIL match_latency_done: got %b, want 1", on_time); end
        n_cmp++; if (blk_err_cnt !== 7'd0) begin n_bad++; $display("FAIL match_err_cnt: got %0d, want 0", blk_err_cnt); end
        n_cmp++; if (blk_max_err !== 8'd0) begin n_bad++; $display("FAIL match_max_err: got %0d, want 0", blk_max_err); end
        n_cmp++; if (blk_pass !== 1'b1) begin n_bad++; $display("FAIL match_pass: got %b, want 1", blk_pass); end
        n_cmp++; if (blk_total !== 16'd1) begin n_bad++; $display("FAIL match_total: got %0d, want 1", blk_total); end
        repeat (4) tick();
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL match_done_pulses: got %0d, want 1", done_cnt - d0); end
        n_cmp++; if (blk_err_cnt !== 7'd0 || blk_pass !== 1'b1) begin n_bad++; $display("FAIL match_hold: got err=%0d pass=%b, want err=0 pass=1", blk_err_cnt, blk_pass); end
    endtask

    // Continues after test_match, so blk_total keeps counting from 1.
    task automatic test_tolerance();
        logic early, on_time;
        int exp_err  [4] = '{1, 0, 64, 2};
        int exp_max  [4] = '{3, 2, 3, 215};
        int exp_pass [4] = '{0, 1, 0, 0};
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < 64; i++) begin in_buf[i] = 8'h28; out_buf[i] = 8'h28; end
            case (v)
                0: out_buf[5] = 8'h2B;
                1: begin out_buf[5] = 8'h2A; out_buf[6] = 8'h26; end
                2: for (int i = 0; i < 64; i++) out_buf[i] = 8'h2B;
                default: begin out_buf[0] = 8'hFF; out_buf[63] = 8'h00; end
            endcase
            send_in(64);
            repeat (3) tick();
            send_out();
            await_report(early, on_time);
            n_cmp++; if (on_time !== 1'b1) begin n_bad++; $display("FAIL tol%0d_done: got %b, want 1", v, on_time); end
            n_cmp++; if (blk_err_cnt !== 7'(exp_err[v])) begin n_bad++; $display("FAIL tol%0d_err_cnt: got %0d, want %0d", v, blk_err_cnt, exp_err[v]); end
            n_cmp++; if (blk_max_err !== 8'(exp_max[v])) begin n_bad++; $display("FAIL tol%0d_max_err: got %0d, want %0d", v, blk_max_err, exp_max[v]); end
            n_cmp++; if (blk_pass !== 1'(exp_pass[v])) begin n_bad++; $display("FAIL tol%0d_pass: got %b, want %0d", v, blk_pass, exp_pass[v]); end
            n_cmp++; if (blk_total !== 16'(v + 2)) begin n_bad++; $display("FAIL tol%0d_total: got %0d, want %0d", v, blk_total, v + 2); end
            repeat (2) tick();
        end
    endtask

    // Eight input blocks with a 26-cycle gap; each is echoed starting 100 cycles after it begins.
    task automatic test_back_to_back();
        int d0, p0;
        do_reset();
        d0 = done_cnt;
        p0 = pass_cnt;
        fork
            begin
                for (int b = 0; b < 8; b++) begin
                    for (int i = 0; i < 64; i++) begin
                        in_valid = 1'b1; xin = pix(b, i);
                        tick();
                    end
                    in_valid = 1'b0;
                    repeat (26) tick();
                end
            end
            begin
                repeat (100) tick();
                for (int b = 0; b < 8; b++) begin
                    for (int i = 0; i < 64; i++) begin
                        out_valid = 1'b1; idct_2d = pix(b, i);
                        tick();
                    end
                    out_valid = 1'b0;
                    repeat (26) tick();
                end
            end
        join
        repeat (4) tick();
        n_cmp++; if (done_cnt - d0 !== 8) begin n_bad++; $display("FAIL b2b_done_pulses: got %0d, want 8", done_cnt - d0); end
        n_cmp++; if (pass_cnt - p0 !== 8) begin n_bad++; $display("FAIL b2b_pass_count: got %0d, want 8", pass_cnt - p0); end
        n_cmp++; if (blk_total !== 16'd8) begin n_bad++; $display("FAIL b2b_total: got %0d, want 8", blk_total); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL b2b_ovf: got %b, want 0", ovf); end
        n_cmp++; if (unf !== 1'b0) begin n_bad++; $display("FAIL b2b_unf: got %b, want 0", unf); end
    endtask

    task automatic test_overflow();
        logic early, on_time;
        do_reset();
        for (int k = 0; k < 192; k++) begin
            in_valid = 1'b1; xin = pix(k / 64, k % 64);
            tick();
            if (k == 127) begin
                n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_at_128: got %b, want 0", ovf); end
            end
            if (k == 128) begin
                n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_at_129: got %b, want 1", ovf); end
            end
        end
        in_valid = 1'b0;
        repeat (3) tick();
        for (int b = 0; b < 2; b++) begin
            load_pattern(b);
            send_out();
            await_report(early, on_time);
            n_cmp++; if (on_time !== 1'b1) begin n_bad++; $display("FAIL ovf_blk%0d_done: got %b, want 1", b, on_time); end
            n_cmp++; if (blk_pass !== 1'b1 || blk_err_cnt !== 7'd0) begin n_bad++; $display("FAIL ovf_blk%0d_stats: got pass=%b err=%0d, want pass=1 err=0", b, blk_pass, blk_err_cnt); end
            n_cmp++; if (blk_total !== 16'(b + 1)) begin n_bad++; $display("FAIL ovf_blk%0d_total: got %0d, want %0d", b, blk_total, b + 1); end
            tick();
        end
        // Dropped samples must not have advanced the write pointer.
        load_pattern(3);
        send_in(64);
        repeat (3) tick();
        send_out();
        await_report(early, on_time);
        n_cmp++; if (on_time !== 1'b1 || blk_pass !== 1'b1) begin n_bad++; $display("FAIL ovf_realign: got done=%b pass=%b, want done=1 pass=1", on_time, blk_pass); end
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b, want 1", ovf); end
    endtask

    task automatic test_underflow();
        int d0;
        do_reset();
        d0 = done_cnt;
        out_valid = 1'b1; idct_2d = 8'h00;
        tick();
        out_valid = 1'b0;
        n_cmp++; if (unf !== 1'b1) begin n_bad++; $display("FAIL unf_set: got %b, want 1", unf); end
        repeat (10) tick();
        n_cmp++; if (unf !== 1'b1) begin n_bad++; $display("FAIL unf_sticky: got %b, want 1", unf); end
        n_cmp++; if (done_cnt - d0 !== 0) begin n_bad++; $display("FAIL unf_no_done: got %0d, want 0", done_cnt - d0); end
        n_cmp++; if (blk_total !== 16'd0) begin n_bad++; $display("FAIL unf_total: got %0d, want 0", blk_total); end
        do_reset();
        n_cmp++; if (unf !== 1'b0) begin n_bad++; $display("FAIL unf_cleared: got %b, want 0", unf); end
    endtask

    task automatic test_mid_reset();
        logic early, on_time;
        int d0;
        do_reset();
        d0 = done_cnt;
        load_pattern(5);
        send_in(30);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        load_pattern(6);
        send_in(64);
        repeat (3) tick();
        send_out();
        await_report(early, on_time);
        n_cmp++; if (on_time !== 1'b1) begin n_bad++; $display("FAIL rst_done: got %b, want 1", on_time); end
        n_cmp++; if (blk_err_cnt !== 7'd0) begin n_bad++; $display("FAIL rst_err_cnt: got %0d, want 0", blk_err_cnt); end
        n_cmp++; if (blk_max_err !== 8'd0) begin n_bad++; $display("FAIL rst_max_err: got %0d, want 0", blk_max_err); end
        n_cmp++; if (blk_total !== 16'd1) begin n_bad++; $display("FAIL rst_total: got %0d, want 1", blk_total); end
        repeat (4) tick();
        n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL rst_done_pulses: got %0d, want 1", done_cnt - d0); end
    endtask

    // A sample landing in the REPORT cycle is flagged and must not shift the next block.
    task automatic test_report_unf();
        logic early, on_time;
        do_reset();
        load_pattern(7);
        send_in(64);
        repeat (3) tick();
        send_out();
        out_valid = 1'b1; idct_2d = 8'h00;
        tick();
        out_valid = 1'b0;
        n_cmp++; if (blk_done !== 1'b1 || blk_pass !== 1'b1) begin n_bad++; $display("FAIL rpt_block: got done=%b pass=%b, want done=1 pass=1", blk_done, blk_pass); end
        n_cmp++; if (unf !== 1'b1) begin n_bad++; $display("FAIL rpt_unf: got %b, want 1", unf); end
        repeat (2) tick();
        load_pattern(8);
        send_in(64);
        repeat (3) tick();
        send_out();
        await_report(early, on_time);
        n_cmp++; if (on_time !== 1'b1 || blk_err_cnt !== 7'd0) begin n_bad++; $display("FAIL rpt_next_block: got done=%b err=%0d, want done=1 err=0", on_time, blk_err_cnt); end
        n_cmp++; if (blk_total !== 16'd2) begin n_bad++; $display("FAIL rpt_total: got %0d, want 2", blk_total); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_tolerance();
        test_back_to_back();
        test_overflow();
        test_underflow();
        test_mid_reset();
        test_report_unf();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
